// File: rtl/llc_cmd_dispatch.sv
// LLC command dispatcher: buffers trace commands in a small FIFO, issues one
// decoded request strobe per command to the cache and waits for its completion.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | nothing in flight; pops the FIFO head when one is available
// S_ISSUE | one-cycle strobe for the held command, counters updated
// S_WAIT  | waiting for cache_done; abandons the command on timeout
module llc_cmd_dispatch #(
    parameter int ADDR_SIZE   = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_op,
    input  logic [ADDR_SIZE-1:0] cmd_addr,
    output logic [ADDR_SIZE-1:0] address,
    output logic                 read_req,
    output logic                 write_req,
    output logic                 invalidate,
    output logic                 snoop_req,
    output logic [1:0]           snoop_op,
    output logic                 clear_req,
    output logic                 print_req,
    input  logic                 cache_done,
    output logic                 busy,
    output logic [CNT_W-1:0]     rd_cnt,
    output logic [CNT_W-1:0]     wr_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int EW = 4 + ADDR_SIZE;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [EW-1:0]          mem_d [FIFO_DEPTH];
    logic [PW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]             op_q, op_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, err_cnt_q, err_cnt_d;
    logic                   full, empty, push, pop, op_legal;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state_q == S_IDLE) && !empty;
    assign op_legal  = (op_q <= 4'd6) || (op_q == 4'd8) || (op_q == 4'd9);

    assign address = addr_q;
    assign busy    = (state_q != S_IDLE) || !empty;
    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;
    assign err_cnt = err_cnt_q;

    // FIFO storage and pointers; push and pop may happen in the same cycle
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[PW-1:0]] = {cmd_op, cmd_addr};
            wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    // Next state, request decode, wait timer and statistics
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        tmr_d      = tmr_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        err_cnt_d  = err_cnt_q;
        read_req   = 1'b0;
        write_req  = 1'b0;
        invalidate = 1'b0;
        snoop_req  = 1'b0;
        snoop_op   = 2'd0;
        clear_req  = 1'b0;
        print_req  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    {op_d, addr_d} = mem_q[rd_ptr_q[PW-1:0]];
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_legal) begin
                    case (op_q)
                        4'd0, 4'd2: begin
                            read_req = 1'b1;
                            rd_cnt_d = sat_inc(rd_cnt_q);
                        end
                        4'd1: begin
                            write_req = 1'b1;
                            wr_cnt_d  = sat_inc(wr_cnt_q);
                        end
                        4'd3:       invalidate = 1'b1;
                        4'd4, 4'd5, 4'd6: begin
                            snoop_req = 1'b1;
                            snoop_op  = 2'(op_q - 4'd4);
                        end
                        4'd8:       clear_req = 1'b1;
                        default:    print_req = 1'b1;
                    endcase
                    if (cache_done) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                        tmr_d   = TW'(TIMEOUT_CYC - 1);
                    end
                end else begin
                    err_cnt_d = sat_inc(err_cnt_q);
                    state_d   = S_IDLE;
                end
            end
            S_WAIT: begin
                // done wins over a coinciding timeout
                if (cache_done) begin
                    state_d = S_IDLE;
                end else if (tmr_q == '0) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                    state_d   = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            tmr_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            tmr_q     <= tmr_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_llc_cmd_dispatch.sv
// Directed bench for llc_cmd_dispatch; inputs change and outputs are read
// 1 time unit after each rising edge.
module tb_llc_cmd_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] address;
    logic        read_req, write_req, invalidate, snoop_req, clear_req, print_req;
    logic [1:0]  snoop_op;
    logic        cache_done = 1'b0;
    logic        busy;
    logic [15:0] rd_cnt, wr_cnt, err_cnt;
    logic [5:0]  strb;

    int n_checks = 0;
    int n_fail   = 0;

    assign strb = {read_req, write_req, invalidate, snoop_req, clear_req, print_req};

    llc_cmd_dispatch dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .address(address),
        .read_req(read_req), .write_req(write_req), .invalidate(invalidate),
        .snoop_req(snoop_req), .snoop_op(snoop_op), .clear_req(clear_req),
        .print_req(print_req), .cache_done(cache_done), .busy(busy),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; cache_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // present a command and hold it until accepted (bounded)
    task automatic push(input logic [3:0] op, input logic [31:0] a);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        if (!cmd_ready) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: cmd_ready stayed 0 for op %0d", op);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({strb, snoop_op} !== 8'h00) begin n_fail++; $display("FAIL reset_strobes: got %b want 0", {strb, snoop_op}); end
        n_checks++;
        if ({rd_cnt, wr_cnt, err_cnt} !== 48'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", {rd_cnt, wr_cnt, err_cnt}); end
        n_checks++;
        if (address !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", address); end
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_ready_busy: got %b%b want 10", cmd_ready, busy); end
    endtask

    task automatic test_read_done();
        int hi;
        do_reset();
        push(4'd0, 32'h1234_5678);
        n_checks++;
        if (read_req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rd_early: read_req=%b busy=%b want 0 1", read_req, busy); end
        tick();
        n_checks++;
        if (strb !== 6'b100000 || address !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_issue: strb=%b addr=%h want 100000 12345678", strb, address); end
        hi = 1;
        for (int i = 0; i < 3; i++) begin tick(); hi += int'(read_req); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_wait_busy: got %b want 1", busy); end
        cache_done = 1'b1;
        tick();
        cache_done = 1'b0;
        hi += int'(read_req);
        n_checks++;
        if (hi !== 1) begin n_fail++; $display("FAIL rd_pulse_len: got %0d want 1", hi); end
        n_checks++;
        if (busy !== 1'b0 || rd_cnt !== 16'd1 || address !== 32'h1234_5678) begin
            n_fail++; $display("FAIL rd_done: busy=%b rd_cnt=%0d addr=%h want 0 1 12345678", busy, rd_cnt, address);
        end
    endtask

    task automatic test_fill_backpressure();
        logic [31:0] a [5];
        for (int i = 0; i < 5; i++) a[i] = 32'hA000_0000 + 32'(i);
        do_reset();
        for (int i = 0; i < 4; i++) push((i % 2 == 0) ? 4'd0 : 4'd2, a[i]);
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready3: got %b want 1", cmd_ready); end
        push(4'd2, a[4]);
        n_checks++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got %b want 0", cmd_ready); end
        cmd_valid = 1'b1; cmd_op = 4'd1; cmd_addr = 32'hDEAD_BEEF;
        tick(); tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (address !== a[0] || busy !== 1'b1) begin n_fail++; $display("FAIL fill_wait_addr: addr=%h want %h", address, a[0]); end
        cache_done = 1'b1;
        tick();
        cache_done = 1'b0;
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL fill_release: got %b want 1", cmd_ready); end
        for (int i = 1; i < 5; i++) begin
            n_checks++;
            if (strb !== 6'b100000 || address !== a[i]) begin
                n_fail++; $display("FAIL fill_order%0d: strb=%b addr=%h want 100000 %h", i, strb, address, a[i]);
            end
            cache_done = 1'b1;
            tick();
            cache_done = 1'b0;
            tick();
        end
        n_checks++;
        if (busy !== 1'b0 || rd_cnt !== 16'd5 || wr_cnt !== 16'd0) begin
            n_fail++; $display("FAIL fill_end: busy=%b rd=%0d wr=%0d want 0 5 0", busy, rd_cnt, wr_cnt);
        end
    endtask

    task automatic test_opcodes();
        logic [3:0] ops [7];
        logic [5:0] exp_s [7];
        logic [1:0] exp_so [7];
        ops    = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        exp_s  = '{6'b010000, 6'b001000, 6'b000100, 6'b000100, 6'b000100, 6'b000010, 6'b000001};
        exp_so = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            push(ops[i], 32'h0000_0100 * 32'(i + 1));
            tick();
            n_checks++;
            if (strb !== exp_s[i] || snoop_op !== exp_so[i] || address !== 32'h0000_0100 * 32'(i + 1)) begin
                n_fail++; $display("FAIL op%0d: strb=%b snoop_op=%0d addr=%h want %b %0d", ops[i], strb, snoop_op, address, exp_s[i], exp_so[i]);
            end
            cache_done = 1'b1;
            tick();
            cache_done = 1'b0;
        end
        n_checks++;
        if (wr_cnt !== 16'd1 || rd_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            n_fail++; $display("FAIL op_cnts: rd=%0d wr=%0d err=%0d want 0 1 0", rd_cnt, wr_cnt, err_cnt);
        end
    endtask

    task automatic test_illegal_timeout();
        int s;
        do_reset();
        push(4'd7, 32'h7777_0000);
        tick();
        n_checks++;
        if (strb !== 6'b000000 || busy !== 1'b1) begin n_fail++; $display("FAIL ill_strobe: strb=%b busy=%b want 000000 1", strb, busy); end
        tick();
        n_checks++;
        if (err_cnt !== 16'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL ill_err: err=%0d busy=%b want 1 0", err_cnt, busy); end
        push(4'd0, 32'h0000_0C00);
        tick();
        n_checks++;
        if (read_req !== 1'b1) begin n_fail++; $display("FAIL to_issue: read_req=%b want 1", read_req); end
        tick();
        s = 0;
        for (int k = 1; k < 64; k++) begin s += int'(|strb); tick(); end
        s += int'(|strb);
        n_checks++;
        if (busy !== 1'b1 || err_cnt !== 16'd1 || s !== 0) begin
            n_fail++; $display("FAIL to_wait64: busy=%b err=%0d strobes=%0d want 1 1 0", busy, err_cnt, s);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || err_cnt !== 16'd2 || address !== 32'h0000_0C00) begin
            n_fail++; $display("FAIL to_expire: busy=%b err=%0d addr=%h want 0 2 00000c00", busy, err_cnt, address);
        end
        push(4'd2, 32'h0000_0D00);
        tick();
        tick();
        for (int k = 1; k < 64; k++) tick();
        cache_done = 1'b1;
        tick();
        cache_done = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || err_cnt !== 16'd2 || rd_cnt !== 16'd2) begin
            n_fail++; $display("FAIL to_coincide: busy=%b err=%0d rd=%0d want 0 2 2", busy, err_cnt, rd_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(4'd0, 32'h0000_00A0);
        push(4'd1, 32'h0000_00B0);
        n_checks++;
        if (strb !== 6'b100000 || address !== 32'h0000_00A0) begin n_fail++; $display("FAIL b2b_first: strb=%b addr=%h want 100000 000000a0", strb, address); end
        cache_done = 1'b1;
        tick();
        cache_done = 1'b0;
        n_checks++;
        if (strb !== 6'b000000 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: strb=%b busy=%b want 000000 1", strb, busy); end
        tick();
        n_checks++;
        if (strb !== 6'b010000 || address !== 32'h0000_00B0) begin n_fail++; $display("FAIL b2b_second: strb=%b addr=%h want 010000 000000b0", strb, address); end
        cache_done = 1'b1;
        tick();
        cache_done = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int s;
        do_reset();
        push(4'd0, 32'h0000_1000);
        push(4'd1, 32'h0000_2000);
        push(4'd0, 32'h0000_3000);
        push(4'd2, 32'h0000_4000);
        n_checks++;
        if (rd_cnt !== 16'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL rmw_pre: rd=%0d busy=%b want 1 1", rd_cnt, busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({rd_cnt, wr_cnt, err_cnt} !== 48'h0 || busy !== 1'b0 || cmd_ready !== 1'b1 || address !== 32'h0) begin
            n_fail++; $display("FAIL rmw_after: cnts=%h busy=%b ready=%b addr=%h want 0 0 1 0", {rd_cnt, wr_cnt, err_cnt}, busy, cmd_ready, address);
        end
        s = 0;
        for (int i = 0; i < 10; i++) begin
            cache_done = (i % 3 == 0);
            tick();
            s += int'(|strb) + int'(busy);
        end
        cache_done = 1'b0;
        n_checks++;
        if (s !== 0) begin n_fail++; $display("FAIL rmw_quiet: activity=%0d want 0", s); end
    endtask

    initial begin
        test_reset();
        test_read_done();
        test_fill_backpressure();
        test_opcodes();
        test_illegal_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
